ex_muldiv: RTL and testbench

Parametrised multi-cycle RV32M/RV64M execute unit that sits beside the single-cycle ALU in the EX stage. It accepts one multiply/divide op at a time through a valid/ready handshake, iterates over several cycles, and returns the result with its destination-register tag. It adds behaviour the single-cycle EX path lacks:

- variable latency
- a pipeline flush
- special-case early-out
- a one-entry result cache, so MULH→MUL and DIV→REM pairs on identical operands complete in one cycle

---
 rtl/ex_muldiv_pkg.sv | 30 +++
 rtl/ex_muldiv_if.sv | 29 ++
 rtl/ex_muldiv_div_core.sv | 49 ++++
 rtl/ex_muldiv.sv | 186 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and types for the multi-cycle mul/div execute unit.
// Imported by the interface, the top and the divider core.
package ex_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  function automatic int mul_iter(int xlen, int mb);
    return xlen / mb;
  endfunction

  localparam int XLEN_DEF     = 32;
  localparam int MUL_BITS_DEF = 2;
  localparam int MUL_ITER     = mul_iter(XLEN_DEF, MUL_BITS_DEF);

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response handshake bundle between EX issue and the mul/div unit.
// master = issuing pipeline, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            flush_in;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [4:0]      out_rd;

  modport master (
    output flush_in, in_valid, in_op,
    output in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd
  );

  modport slave (
    input  flush_in, in_valid, in_op,
    input  in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd
  );
endinterface

// File: rtl/ex_muldiv_div_core.sv
// Restoring divider datapath, one quotient bit per enabled step.
// i_start loads the operands and performs the first step in the same edge.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dvd,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;

  logic [XLEN-1:0] w_rem_in;
  logic [XLEN-1:0] w_quo_in;
  logic [XLEN-1:0] w_dvs_in;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  assign w_rem_in = i_start ? '0 : r_rem;
  assign w_quo_in = i_start ? i_dvd : r_quo;
  assign w_dvs_in = i_start ? i_dvs : r_dvs;

  // partial remainder stays below the divisor, so a borrow out means "less than"
  assign w_sh   = {w_rem_in, w_quo_in[XLEN-1]};
  assign w_diff = w_sh - {1'b0, w_dvs_in};
  assign w_ge   = ~w_diff[XLEN];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_start || i_step) begin
      r_dvs <= w_dvs_in;
      r_rem <= w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
      r_quo <= {w_quo_in[XLEN-2:0], w_ge};
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M unit: shift-add multiplier, restoring divider,
// special-case early-out and a one-entry mul / one-entry div result cache.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input logic         clk_in,
  input logic         rst_in,
  ex_muldiv_if.slave  bus
);
  localparam int ITER = mul_iter(XLEN, MUL_BITS);
  localparam int CW   = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e r_state, w_next;

  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_rs1, r_rs2;
  logic [1:0]        r_cls;
  logic [XLEN-1:0]   r_ma;
  logic              r_negp, r_negr;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_out_data;
  logic [4:0]        r_out_rd;

  logic              r_mv, r_dv, r_d_sgn;
  logic [1:0]        r_m_cls;
  logic [XLEN-1:0]   r_m_rs1, r_m_rs2, r_d_rs1, r_d_rs2;
  logic [XLEN-1:0]   r_d_quo, r_d_rem;
  logic [2*XLEN-1:0] r_m_prod;

  logic w_accept, w_mstep, w_dstep, w_fix, w_dstart;
  logic w_isdiv, w_s1, w_s2, w_n1, w_n2;
  logic w_mhit, w_dhit, w_dz, w_ovf, w_fast;
  logic [1:0]        w_cls;
  logic [XLEN-1:0]   w_m1, w_m2, w_fast_data, w_fix_data;
  logic [XLEN-1:0]   w_dq, w_dr, w_quo, w_rem, w_src_a;
  logic [XLEN-1:0]   w_src_lo, w_src_hi;
  logic [MUL_BITS-1:0] w_dig;
  logic [XLEN+MUL_BITS-1:0] w_pp, w_sum;
  logic [2*XLEN-1:0] w_acc_nx, w_prod;

  assign w_isdiv = bus.in_op[2];
  // plain MUL computes unsigned; its low half matches every class
  assign w_cls = (bus.in_op == OP_MUL) ? 2'd3 : bus.in_op[1:0];
  assign w_s1  = w_isdiv ? ~bus.in_op[0] : (w_cls == 2'd1 || w_cls == 2'd2);
  assign w_s2  = w_isdiv ? ~bus.in_op[0] : (w_cls == 2'd1);
  assign w_n1  = w_s1 & bus.in_rs1[XLEN-1];
  assign w_n2  = w_s2 & bus.in_rs2[XLEN-1];
  assign w_m1  = w_n1 ? -bus.in_rs1 : bus.in_rs1;
  assign w_m2  = w_n2 ? -bus.in_rs2 : bus.in_rs2;

  assign w_mhit = r_mv && bus.in_rs1 == r_m_rs1 && bus.in_rs2 == r_m_rs2
               && (bus.in_op == OP_MUL || r_m_cls == bus.in_op[1:0]);
  assign w_dhit = r_dv && bus.in_rs1 == r_d_rs1 && bus.in_rs2 == r_d_rs2
               && r_d_sgn == ~bus.in_op[0];
  assign w_dz   = w_isdiv && bus.in_rs2 == '0;
  assign w_ovf  = w_isdiv && !bus.in_op[0]
               && bus.in_rs1 == MINV && bus.in_rs2 == '1;
  assign w_fast = (w_isdiv ? w_dhit : w_mhit) || w_dz || w_ovf;

  always_comb begin
    w_fast_data = '0;
    unique case (1'b1)
      (w_isdiv && w_dhit):   w_fast_data = bus.in_op[1] ? r_d_rem : r_d_quo;
      (!w_isdiv):            w_fast_data = (bus.in_op == OP_MUL)
                               ? r_m_prod[XLEN-1:0] : r_m_prod[2*XLEN-1:XLEN];
      (w_isdiv && !w_dhit && w_dz):
                             w_fast_data = bus.in_op[1] ? bus.in_rs1 : '1;
      default:               w_fast_data = bus.in_op[1] ? '0 : bus.in_rs1;
    endcase
  end

  // the accept edge already performs the first multiplier step
  assign w_src_a  = (r_state == S_MUL) ? r_ma : w_m1;
  assign w_src_lo = (r_state == S_MUL) ? r_acc[XLEN-1:0] : w_m2;
  assign w_src_hi = (r_state == S_MUL) ? r_acc[2*XLEN-1:XLEN] : '0;
  assign w_dig    = w_src_lo[MUL_BITS-1:0];
  assign w_pp     = (XLEN+MUL_BITS)'(w_src_a) * (XLEN+MUL_BITS)'(w_dig);
  assign w_sum    = (XLEN+MUL_BITS)'(w_src_hi) + w_pp;
  assign w_acc_nx = {w_sum, w_src_lo[XLEN-1:MUL_BITS]};

  assign w_prod = r_negp ? -r_acc : r_acc;
  assign w_quo  = r_negp ? -w_dq : w_dq;
  assign w_rem  = r_negr ? -w_dr : w_dr;
  assign w_fix_data = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                    : (r_op == OP_MUL) ? w_prod[XLEN-1:0]
                    : w_prod[2*XLEN-1:XLEN];

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_start (w_dstart),
    .i_step  (w_dstep),
    .i_dvd   (w_m1),
    .i_dvs   (w_m2),
    .o_quo   (w_dq),
    .o_rem   (w_dr)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush_in) w_next = S_IDLE;
    else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (r_state == S_DONE && !bus.out_ready) w_next = S_DONE;
          else if (w_accept)
            w_next = w_fast ? S_DONE : (w_isdiv ? S_DIV : S_MUL);
          else w_next = S_IDLE;
        end
        S_MUL: if (r_cnt == CW'(ITER-1)) w_next = S_FIX;
        S_DIV: if (r_cnt == CW'(XLEN-1)) w_next = S_FIX;
        S_FIX: w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE)
                 || (r_state == S_DONE && bus.out_ready);
    bus.out_valid = (r_state == S_DONE);
    w_accept = bus.in_valid && bus.in_ready && !bus.flush_in;
    w_mstep  = (r_state == S_MUL) && !bus.flush_in;
    w_dstep  = (r_state == S_DIV) && !bus.flush_in;
    w_fix    = (r_state == S_FIX) && !bus.flush_in;
    w_dstart = w_accept && w_isdiv && !w_fast;
  end

  assign bus.out_data = r_out_data;
  assign bus.out_rd   = r_out_rd;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_op <= '0; r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0;
      r_cls <= '0; r_ma <= '0; r_negp <= 1'b0; r_negr <= 1'b0;
      r_acc <= '0; r_cnt <= '0; r_out_data <= '0; r_out_rd <= '0;
      r_mv <= 1'b0; r_m_cls <= '0; r_m_rs1 <= '0; r_m_rs2 <= '0;
      r_m_prod <= '0; r_dv <= 1'b0; r_d_sgn <= 1'b0;
      r_d_rs1 <= '0; r_d_rs2 <= '0; r_d_quo <= '0; r_d_rem <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.in_op;
        r_rd   <= bus.in_rd;
        r_rs1  <= bus.in_rs1;
        r_rs2  <= bus.in_rs2;
        r_cls  <= w_cls;
        r_ma   <= w_m1;
        r_acc  <= w_acc_nx;
        r_negp <= w_n1 ^ w_n2;
        r_negr <= w_n1;
        r_cnt  <= CW'(1);
        if (w_fast) begin
          r_out_data <= w_fast_data;
          r_out_rd   <= bus.in_rd;
        end
      end
      if (w_mstep) begin
        r_acc <= w_acc_nx;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_dstep) r_cnt <= r_cnt + 1'b1;
      if (w_fix) begin
        r_out_data <= w_fix_data;
        r_out_rd   <= r_rd;
        if (r_op[2]) begin
          r_dv <= 1'b1; r_d_rs1 <= r_rs1; r_d_rs2 <= r_rs2;
          r_d_sgn <= ~r_op[0]; r_d_quo <= w_quo; r_d_rem <= w_rem;
        end else begin
          r_mv <= 1'b1; r_m_rs1 <= r_rs1; r_m_rs2 <= r_rs2;
          r_m_cls <= r_cls; r_m_prod <= w_prod;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed vector bench for ex_muldiv: results, tags, latencies,
// cache hits/misses, flush, back-pressure and asynchronous reset.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv #(.XLEN(32), .MUL_BITS(2)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t v[16];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic accept(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int k = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_rs1 = a; bus.in_rs2 = b; bus.in_rd = rd;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // counts the accept edge as edge 1
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int seen;

    v[0]  = '{OP_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 17};
    v[1]  = '{OP_MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1};
    v[2]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    v[3]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1};
    v[4]  = '{OP_REMU,   32'hFFFFFFF9, 32'd2,        32'd1,        33};
    v[5]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
    v[6]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    v[7]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17};
    v[8]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17};
    v[9]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
    v[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    v[11] = '{OP_REMU,   32'd9,        32'd0,        32'd9,        1};
    v[12] = '{OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 17};
    v[13] = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 17};
    v[14] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
    v[15] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1};

    bus.flush_in = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;

    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", bus.out_data, 32'd0);
    chk("rst out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      accept(v[i].op, v[i].a, v[i].b, 5'(i + 1));
      wait_done(lat);
      chk($sformatf("v%0d data", i), bus.out_data, v[i].exp);
      chk($sformatf("v%0d rd", i), 32'(bus.out_rd), 32'(i + 1));
      chk($sformatf("v%0d lat", i), 32'(lat), 32'(v[i].lat));
      take();
    end

    accept(OP_DIV, 32'd1000, 32'd7, 5'd20);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush_in = 1'b1;
    @(posedge clk);
    #1;
    chk("flush idle", 32'(bus.in_ready), 32'd1);
    chk("flush valid", 32'(bus.out_valid), 32'd0);
    bus.flush_in = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen = 1;
    end
    chk("flush no valid", 32'(seen), 32'd0);
    accept(OP_REM, 32'd1000, 32'd7, 5'd21);
    wait_done(lat);
    chk("flush rem data", bus.out_data, 32'd6);
    chk("flush rem lat", 32'(lat), 32'd33);
    take();

    accept(OP_MUL, 32'd3, 32'd5, 5'd22);
    wait_done(lat);
    chk("bp lat", 32'(lat), 32'd17);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_data !== 32'd15 || bus.out_rd !== 5'd22 ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    chk("bp hold", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = OP_DIVU; bus.in_rs1 = 32'd5; bus.in_rs2 = 32'd0;
    bus.in_rd = 5'd23;
    #1 chk("bp in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("bp next valid", 32'(bus.out_valid), 32'd1);
    chk("bp next rd", 32'(bus.out_rd), 32'd23);
    chk("bp next data", bus.out_data, 32'hFFFFFFFF);
    take();

    accept(OP_MULHU, 32'd1, 32'd1, 5'd24);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(bus.out_valid), 32'd0);
    chk("arst ready", 32'(bus.in_ready), 32'd1);
    chk("arst rd", 32'(bus.out_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(OP_MUL, 32'd3, 32'd5, 5'd25);
    wait_done(lat);
    chk("arst mul data", bus.out_data, 32'd15);
    chk("arst mul rd", 32'(bus.out_rd), 32'd25);
    chk("arst mul lat", 32'(lat), 32'd17);
    take();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
